// File: rtl/x96_prefetch_queue.sv
// ---------------------------------------------------------------------------
// x96_prefetch_queue
//
// Instruction prefetch unit for the 8096 core. Builds 20-bit physical fetch
// addresses from CS:IP, issues single-byte reads to the memory fabric with a
// bounded number in flight, buffers the returned bytes in a small FIFO and
// presents them to the decoder tagged with the IP they were fetched from.
// A flush redirects the stream and discards anything still in flight.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   fetch_en                allow issue of new fetch requests
//   flush_valid/_cs/_ip     redirect the fetch stream to flush_cs:flush_ip
//   req_valid/ready/addr    fetch request handshake to the fabric
//   rsp_valid/data/err      in-order byte responses from the fabric
//   dq_valid/ready          decoder-side pop handshake
//   dq_byte/ip/fault        head entry of the byte FIFO
//   dq_count                FIFO occupancy
// ---------------------------------------------------------------------------
module x96_prefetch_queue #(
    parameter int          QUEUE_BYTES     = 6,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [15:0] RESET_CS        = 16'h0000,
    parameter logic [15:0] RESET_IP        = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        flush_valid,
    input  logic [15:0] flush_cs,
    input  logic [15:0] flush_ip,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [19:0] req_addr,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_err,
    output logic        dq_valid,
    input  logic        dq_ready,
    output logic [7:0]  dq_byte,
    output logic [15:0] dq_ip,
    output logic        dq_fault,
    output logic [4:0]  dq_count
);

    localparam int             PW      = $clog2(QUEUE_BYTES);
    localparam logic [PW-1:0]  LAST    = PW'(QUEUE_BYTES - 1);
    localparam logic [5:0]     QB      = 6'(QUEUE_BYTES);
    localparam logic [2:0]     MAX_OUT = 3'(MAX_OUTSTANDING);

    logic [15:0]   cs_q, cs_d;
    logic [15:0]   ip_q, ip_d;
    logic [15:0]   tag_q, tag_d;
    logic          reqValid_q, reqValid_d;
    logic [19:0]   reqAddr_q, reqAddr_d;
    logic [2:0]    outst_q, outst_d;
    logic [2:0]    stale_q, stale_d;
    logic          faulted_q, faulted_d;
    logic          pendStale_q, pendStale_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [4:0]    count_q, count_d;

    logic [7:0]    byteMem_q  [QUEUE_BYTES];
    logic [15:0]   ipMem_q    [QUEUE_BYTES];
    logic          faultMem_q [QUEUE_BYTES];

    logic          accept;
    logic          push;
    logic          pop;
    logic          rspFault;
    logic          canIssue;
    logic [5:0]    occupancy;

    function automatic logic [PW-1:0] bumpPtr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Handshake qualifiers. A flush cycle neither pushes nor pops; a response
    // owed to a pre-flush request (stale_q != 0) is swallowed instead of pushed.
    // Issue is also held off in the cycle a fault arrives so nothing new gets
    // requested behind the fault marker.
    always_comb begin
        accept    = reqValid_q & req_ready;
        push      = rsp_valid & (stale_q == 3'd0) & ~flush_valid;
        pop       = (count_q != 5'd0) & dq_ready & ~flush_valid;
        rspFault  = push & rsp_err;
        occupancy = {1'b0, count_q} + {3'b000, outst_q} + {5'b00000, reqValid_q};
        canIssue  = fetch_en & ~faulted_q & ~rspFault & ~flush_valid &
                    ~reqValid_q & (outst_q < MAX_OUT) & (occupancy < QB);
    end

    // Next-state logic. Normal request/response/pop bookkeeping first, then
    // the flush overrides the stream state. A request still pending at flush
    // keeps its old address; pendStale remembers that its acceptance must not
    // advance the new stream's IP.
    always_comb begin
        cs_d        = cs_q;
        ip_d        = ip_q;
        tag_d       = tag_q;
        reqValid_d  = reqValid_q;
        reqAddr_d   = reqAddr_q;
        outst_d     = outst_q + {2'b00, accept} - {2'b00, rsp_valid};
        stale_d     = stale_q;
        faulted_d   = faulted_q;
        pendStale_d = pendStale_q;
        rdPtr_d     = rdPtr_q;
        wrPtr_d     = wrPtr_q;
        count_d     = count_q + {4'b0000, push} - {4'b0000, pop};

        if (accept) begin
            reqValid_d  = 1'b0;
            pendStale_d = 1'b0;
            if (!pendStale_q) begin
                ip_d = ip_q + 16'd1;
            end
        end

        if (canIssue) begin
            reqValid_d = 1'b1;
            reqAddr_d  = {cs_q, 4'h0} + {4'h0, ip_q};
        end

        if (rsp_valid && (stale_q != 3'd0)) begin
            stale_d = stale_q - 3'd1;
        end

        if (push) begin
            wrPtr_d = bumpPtr(wrPtr_q);
            tag_d   = tag_q + 16'd1;
            if (rsp_err) begin
                faulted_d = 1'b1;
            end
        end

        if (pop) begin
            rdPtr_d = bumpPtr(rdPtr_q);
        end

        if (flush_valid) begin
            cs_d        = flush_cs;
            ip_d        = flush_ip;
            tag_d       = flush_ip;
            faulted_d   = 1'b0;
            rdPtr_d     = '0;
            wrPtr_d     = '0;
            count_d     = 5'd0;
            stale_d     = outst_q + {2'b00, reqValid_q} - {2'b00, rsp_valid};
            pendStale_d = reqValid_q & ~req_ready;
        end
    end

    // Control and stream state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q        <= RESET_CS;
            ip_q        <= RESET_IP;
            tag_q       <= RESET_IP;
            reqValid_q  <= 1'b0;
            reqAddr_q   <= 20'h00000;
            outst_q     <= 3'd0;
            stale_q     <= 3'd0;
            faulted_q   <= 1'b0;
            pendStale_q <= 1'b0;
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            count_q     <= 5'd0;
        end else begin
            cs_q        <= cs_d;
            ip_q        <= ip_d;
            tag_q       <= tag_d;
            reqValid_q  <= reqValid_d;
            reqAddr_q   <= reqAddr_d;
            outst_q     <= outst_d;
            stale_q     <= stale_d;
            faulted_q   <= faulted_d;
            pendStale_q <= pendStale_d;
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage needs no reset: the head is only visible while count != 0.
    // A fault entry stores a zero byte rather than whatever the bus returned.
    always_ff @(posedge clk) begin
        if (push) begin
            byteMem_q[wrPtr_q]  <= rsp_err ? 8'h00 : rsp_data;
            ipMem_q[wrPtr_q]    <= tag_q;
            faultMem_q[wrPtr_q] <= rsp_err;
        end
    end

    // Head is shown straight from storage and forced to zero when empty.
    always_comb begin
        req_valid = reqValid_q;
        req_addr  = reqAddr_q;
        dq_valid  = (count_q != 5'd0);
        dq_count  = count_q;
        dq_byte   = 8'h00;
        dq_ip     = 16'h0000;
        dq_fault  = 1'b0;
        if (dq_valid) begin
            dq_byte  = byteMem_q[rdPtr_q];
            dq_ip    = ipMem_q[rdPtr_q];
            dq_fault = faultMem_q[rdPtr_q];
        end
    end

endmodule

// File: tb/tb_x96_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_x96_prefetch_queue
//
// Self-checking bench for x96_prefetch_queue. A fabric model accepts fetch
// requests, checks their addresses against an expected-address queue and
// returns bytes from a fixed memory image after a programmable latency. The
// decoder-side monitor pops expected {byte, ip, fault} entries from a
// scoreboard on every dq handshake. Stimulus drives on the falling edge.
// ---------------------------------------------------------------------------
module tb_x96_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        flush_valid;
    logic [15:0] flush_cs;
    logic [15:0] flush_ip;
    logic        req_valid;
    logic        req_ready;
    logic [19:0] req_addr;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        dq_valid;
    logic        dq_ready;
    logic [7:0]  dq_byte;
    logic [15:0] dq_ip;
    logic        dq_fault;
    logic [4:0]  dq_count;

    typedef struct packed {
        logic [7:0]  b;
        logic [15:0] ip;
        logic        f;
    } dqEnt_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          errAddr  = -1;
    bit          randReady = 1'b0;
    int          popCount = 0;
    logic [19:0] expAddrQ[$];
    dqEnt_t      sbQ[$];
    logic [19:0] inflAddr[$];
    int          inflDue[$];
    bit          prevWait = 1'b0;
    logic [19:0] prevAddr = 20'h0;

    x96_prefetch_queue #(
        .QUEUE_BYTES(6),
        .MAX_OUTSTANDING(2),
        .RESET_CS(16'h0000),
        .RESET_IP(16'h0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fetch_en(fetch_en),
        .flush_valid(flush_valid),
        .flush_cs(flush_cs),
        .flush_ip(flush_ip),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .dq_valid(dq_valid),
        .dq_ready(dq_ready),
        .dq_byte(dq_byte),
        .dq_ip(dq_ip),
        .dq_fault(dq_fault),
        .dq_count(dq_count)
    );

    // 10 ns clock and a posedge counter used to schedule fabric responses.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory image: the first eight bytes are the boot program, the rest a
    // simple address-derived pattern.
    function automatic logic [7:0] memByte(input logic [19:0] a);
        case (a)
            20'h00000: return 8'hB8;
            20'h00001: return 8'hFF;
            20'h00002: return 8'hFF;
            20'h00003: return 8'h8E;
            20'h00004: return 8'hD8;
            20'h00005: return 8'hB8;
            20'h00006: return 8'h34;
            20'h00007: return 8'h12;
            default:   return a[7:0] + a[15:8] + {4'h0, a[19:16]} + 8'h11;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic expectAddr(input logic [19:0] a);
        expAddrQ.push_back(a);
    endtask

    task automatic expectByte(input logic [7:0] b, input logic [15:0] ip,
                              input logic f);
        dqEnt_t e;
        e.b  = b;
        e.ip = ip;
        e.f  = f;
        sbQ.push_back(e);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "ReqValid"}, req_valid, 0);
        checkOutput({tag, "ReqAddr"},  req_addr,  0);
        checkOutput({tag, "DqValid"},  dq_valid,  0);
        checkOutput({tag, "DqByte"},   dq_byte,   0);
        checkOutput({tag, "DqIp"},     dq_ip,     0);
        checkOutput({tag, "DqFault"},  dq_fault,  0);
        checkOutput({tag, "DqCount"},  dq_count,  0);
    endtask

    // Flush for one cycle from a falling edge; the FIFO must read empty on
    // the following cycle.
    task automatic applyStimulus(input logic [15:0] cs, input logic [15:0] ip);
        flush_valid = 1'b1;
        flush_cs    = cs;
        flush_ip    = ip;
        sbQ.delete();
        @(negedge clk);
        flush_valid = 1'b0;
        checkOutput("dqValidAfterFlush", dq_valid, 0);
    endtask

    task automatic waitFull(input int n, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dq_count == 5'(n) && !req_valid && inflAddr.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput({name, "Settled"}, done, 1);
        checkOutput({name, "Count"}, dq_count, n);
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        dq_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!dq_valid && !req_valid && inflAddr.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        dq_ready = 1'b0;
        checkOutput({name, "Drained"}, done, 1);
        checkOutput({name, "SbLeft"}, sbQ.size(), 0);
    endtask

    task automatic watchIdle(input string name, input int n);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (req_valid) seen = 1'b1;
        end
        checkOutput(name, seen, 0);
    endtask

    // Fabric model: checks request hold and address order, then returns
    // bytes in order after 'lat' cycles. Cleared by reset with the core.
    always begin
        logic [19:0] a;
        @(negedge clk);
        #1;
        if (!rst_n) begin
            inflAddr.delete();
            inflDue.delete();
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            rsp_data  = 8'h00;
            rsp_err   = 1'b0;
            prevWait  = 1'b0;
        end else begin
            if (prevWait) begin
                checkOutput("reqHoldValid", req_valid, 1);
                checkOutput("reqHoldAddr", req_addr, prevAddr);
            end
            req_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (req_valid && req_ready) begin
                if (expAddrQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL reqAddrUnexpected actual=0x%0h required=none", req_addr);
                end else begin
                    checkOutput("reqAddr", req_addr, expAddrQ.pop_front());
                end
                inflAddr.push_back(req_addr);
                inflDue.push_back(cyc + lat);
            end
            prevWait  = req_valid && !req_ready;
            prevAddr  = req_addr;
            rsp_valid = 1'b0;
            rsp_data  = 8'h00;
            rsp_err   = 1'b0;
            if (inflDue.size() > 0 && inflDue[0] <= cyc) begin
                a = inflAddr.pop_front();
                void'(inflDue.pop_front());
                rsp_valid = 1'b1;
                rsp_data  = memByte(a);
                rsp_err   = (int'(a) == errAddr);
            end
        end
    end

    // Decoder-side monitor: compares the head against the scoreboard on
    // every cycle that will complete a pop.
    always begin
        dqEnt_t e;
        @(negedge clk);
        #2;
        if (rst_n && !flush_valid && dq_valid && dq_ready) begin
            popCount++;
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL dqUnexpected actual=0x%0h required=none", dq_byte);
            end else begin
                e = sbQ.pop_front();
                checkOutput("dqByte", dq_byte, e.b);
                checkOutput("dqIp", dq_ip, e.ip);
                checkOutput("dqFault", dq_fault, e.f);
            end
        end
    end

    // Occupancy bound: buffered bytes plus accepted-unanswered requests can
    // never exceed the FIFO depth.
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            checkOutput("occupancyBound", (32'(dq_count) + 32'(inflAddr.size()) <= 32'd6), 1);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        fetch_en    = 1'b0;
        flush_valid = 1'b0;
        flush_cs    = 16'h0000;
        flush_ip    = 16'h0000;
        dq_ready    = 1'b0;
        repeat (3) @(negedge clk);
        checkReset("reset");

        // Boot fetch: six bytes from 0x00000 fill the queue, then issue stops.
        for (int i = 0; i < 6; i++) expectAddr(20'(i));
        expectByte(8'hB8, 16'h0000, 1'b0);
        expectByte(8'hFF, 16'h0001, 1'b0);
        expectByte(8'hFF, 16'h0002, 1'b0);
        expectByte(8'h8E, 16'h0003, 1'b0);
        expectByte(8'hD8, 16'h0004, 1'b0);
        expectByte(8'hB8, 16'h0005, 1'b0);
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        waitFull(6, "boot");
        checkOutput("bootHeadByte", dq_byte, 8'hB8);
        checkOutput("bootHeadIp", dq_ip, 16'h0000);
        checkOutput("bootHeadFault", dq_fault, 0);
        watchIdle("bootReqIdleFull", 10);
        fetch_en = 1'b0;
        drain("boot");

        // Segment wrap: FFFF:0100 -> 0x000F0.
        applyStimulus(16'hFFFF, 16'h0100);
        for (int i = 0; i < 6; i++) expectAddr(20'h000F0 + 20'(i));
        expectByte(8'h01, 16'h0100, 1'b0);
        expectByte(8'h02, 16'h0101, 1'b0);
        expectByte(8'h03, 16'h0102, 1'b0);
        expectByte(8'h04, 16'h0103, 1'b0);
        expectByte(8'h05, 16'h0104, 1'b0);
        expectByte(8'h06, 16'h0105, 1'b0);
        fetch_en = 1'b1;
        waitFull(6, "segWrap");
        fetch_en = 1'b0;
        drain("segWrap");

        // IP wrap inside segment 0x1000.
        applyStimulus(16'h1000, 16'hFFFF);
        expectAddr(20'h1FFFF);
        for (int i = 0; i < 5; i++) expectAddr(20'h10000 + 20'(i));
        expectByte(8'h10, 16'hFFFF, 1'b0);
        expectByte(8'h12, 16'h0000, 1'b0);
        expectByte(8'h13, 16'h0001, 1'b0);
        expectByte(8'h14, 16'h0002, 1'b0);
        expectByte(8'h15, 16'h0003, 1'b0);
        expectByte(8'h16, 16'h0004, 1'b0);
        fetch_en = 1'b1;
        waitFull(6, "ipWrap");
        fetch_en = 1'b0;
        drain("ipWrap");

        // Flush with two requests outstanding at latency 3: both old bytes
        // must be dropped and the new stream starts at 0x0028.
        lat = 3;
        applyStimulus(16'h0000, 16'h0000);
        expectAddr(20'h00000);
        expectAddr(20'h00001);
        for (int i = 0; i < 6; i++) expectAddr(20'h00028 + 20'(i));
        fetch_en = 1'b1;
        begin
            bit got2 = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (inflAddr.size() == 2) begin
                    got2 = 1'b1;
                    break;
                end
            end
            checkOutput("staleTwoOutstanding", got2, 1);
        end
        applyStimulus(16'h0000, 16'h0028);
        expectByte(8'h39, 16'h0028, 1'b0);
        expectByte(8'h3A, 16'h0029, 1'b0);
        expectByte(8'h3B, 16'h002A, 1'b0);
        expectByte(8'h3C, 16'h002B, 1'b0);
        expectByte(8'h3D, 16'h002C, 1'b0);
        expectByte(8'h3E, 16'h002D, 1'b0);
        waitFull(6, "stale");
        checkOutput("staleHeadByte", dq_byte, 8'h39);
        checkOutput("staleHeadIp", dq_ip, 16'h0028);
        fetch_en = 1'b0;
        drain("stale");
        lat = 1;

        // Bus fault on 0x00004: four good bytes, then the fault marker, and
        // no further issue even with an empty queue until the next flush.
        applyStimulus(16'h0000, 16'h0000);
        errAddr = 4;
        for (int i = 0; i < 5; i++) expectAddr(20'(i));
        expectByte(8'hB8, 16'h0000, 1'b0);
        expectByte(8'hFF, 16'h0001, 1'b0);
        expectByte(8'hFF, 16'h0002, 1'b0);
        expectByte(8'h8E, 16'h0003, 1'b0);
        expectByte(8'h00, 16'h0004, 1'b1);
        fetch_en = 1'b1;
        waitFull(5, "fault");
        watchIdle("faultReqIdle", 10);
        drain("fault");
        watchIdle("faultReqIdleEmpty", 10);
        errAddr = -1;
        applyStimulus(16'h0000, 16'h0040);
        for (int i = 0; i < 6; i++) expectAddr(20'h00040 + 20'(i));
        expectByte(8'h51, 16'h0040, 1'b0);
        expectByte(8'h52, 16'h0041, 1'b0);
        expectByte(8'h53, 16'h0042, 1'b0);
        expectByte(8'h54, 16'h0043, 1'b0);
        expectByte(8'h55, 16'h0044, 1'b0);
        expectByte(8'h56, 16'h0045, 1'b0);
        waitFull(6, "faultClear");
        fetch_en = 1'b0;
        drain("faultClear");

        // Throttled stream with random fabric and decoder stalls, then a
        // reset mid-burst and a restart from 0x00000.
        lat = 2;
        applyStimulus(16'h2000, 16'h0000);
        for (int i = 0; i < 300; i++) begin
            expectAddr(20'h20000 + 20'(i));
            expectByte(memByte(20'h20000 + 20'(i)), 16'(i), 1'b0);
        end
        randReady = 1'b1;
        fetch_en  = 1'b1;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            dq_ready = 1'($urandom_range(0, 1));
        end
        rst_n    = 1'b0;
        dq_ready = 1'b0;
        sbQ.delete();
        expAddrQ.delete();
        @(negedge clk);
        checkReset("midReset");
        for (int i = 0; i < 300; i++) begin
            expectAddr(20'(i));
            expectByte(memByte(20'(i)), 16'(i), 1'b0);
        end
        popCount = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            dq_ready = 1'($urandom_range(0, 1));
        end
        fetch_en = 1'b0;
        begin
            bit done = 1'b0;
            dq_ready = 1'b1;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (!dq_valid && !req_valid && inflAddr.size() == 0) begin
                    done = 1'b1;
                    break;
                end
            end
            dq_ready = 1'b0;
            checkOutput("throttleDrained", done, 1);
        end
        checkOutput("throttlePopsAfterReset", (popCount >= 6), 1);
        randReady = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/x96_prefetch_queue.md
Name: x96_prefetch_queue

Overview:
- Instruction prefetch unit for the 8096 core. Sits between the core's memory fabric port and the decoder.
- Forms 20-bit physical fetch addresses from CS:IP and issues byte reads with up to MAX_OUTSTANDING in flight.
- Buffers returned bytes in a FIFO and hands them to the decoder, each tagged with its IP.
- Branches, MODEUP and traps redirect it through a flush that discards stale data.

Parameters:
- QUEUE_BYTES, 6: byte FIFO depth (2..16).
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered fetch requests (1..4).
- RESET_CS, 16'h0000: CS after reset.
- RESET_IP, 16'h0000: IP after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  allow issue of new requests
- flush_valid  in  1  redirect fetch stream
- flush_cs  in  16  new CS
- flush_ip  in  16  new IP
- req_valid  out  1  fetch request valid
- req_ready  in  1  fabric accepts request
- req_addr  out  20  physical byte address
- rsp_valid  in  1  response valid (in order)
- rsp_data  in  8  fetched byte
- rsp_err  in  1  bus fault on this response
- dq_valid  out  1  head byte available
- dq_ready  in  1  decoder pops head
- dq_byte  out  8  head byte
- dq_ip  out  16  IP of head byte
- dq_fault  out  1  head entry is a fault marker
- dq_count  out  5  FIFO occupancy

Behaviour:
- Reset (async, any state): FIFO empty, outstanding=0, stale=0, faulted=0, fetch CS:IP=RESET_CS:RESET_IP.
  - Outputs: req_valid=0, req_addr=0, dq_valid=0, dq_byte=0, dq_ip=0, dq_fault=0, dq_count=0.
  - A reset mid-transaction abandons all in-flight requests. Fabric is reset with the core.
- Address rule: req_addr = ({cs,4'h0} + {4'h0,ip})[19:0], so addresses wrap modulo 2^20.
  - Fetch IP increments modulo 2^16 per accepted request; CS is unchanged.
- Issue: req_valid is registered. It is set the cycle after all of the following hold:
  - fetch_en=1
  - faulted=0
  - outstanding < MAX_OUTSTANDING
  - count + outstanding (+1 if req_valid already pending) < QUEUE_BYTES
- Handshake: once asserted, req_valid and req_addr hold until req_ready. There is no retraction, including across flush.
  - On accept: outstanding+1, IP+1. The next request may issue the following cycle (1 req/2 cycles minimum).
- Response: on rsp_valid, outstanding-1.
  - If stale>0: stale-1 and the byte is dropped.
  - Otherwise: push {rsp_data, ip_tag, rsp_err}. ip_tag is an IP shadow counter advancing on each push.
  - If rsp_err=1: push marker with dq_fault=1, dq_byte=0, set faulted, stop issuing.
  - FIFO space is guaranteed by the issue rule; overflow is impossible. The bench asserts this.
- Pop: dq_valid = count!=0. Head is shown combinationally from FIFO storage; a handshake occurs when dq_valid & dq_ready.
  - Push and pop in the same cycle leave count unchanged; an empty FIFO does not bypass rsp to dq in the same cycle.
- Flush (highest priority, single cycle):
  - FIFO emptied; faulted=0; fetch CS:IP and ip_tag set to flush_cs:flush_ip.
  - stale = outstanding, plus 1 if a request is accepted this cycle, plus 1 if req_valid remains pending unaccepted, minus 1 if a response arrives this cycle.
  - A pop in the flush cycle is ignored. A response arriving in the flush cycle is dropped.
  - A pending req_valid keeps its old address and is counted stale. New-stream requests start only after it is accepted.
  - dq_valid=0 the cycle after flush.
- fetch_en=0 blocks new issue only. Pending and outstanding requests complete normally.
- Fault: the marker is delivered in order after earlier good bytes. No further issue until flush. dq_count includes the marker.

Test Plan:
- Reset, mem[0..7]=B8 FF FF 8E D8 B8 34 12, dq_ready=0, latency 1:
  - req_addr sequence 0x00000..0x00005, then req_valid stays 0.
  - dq_count=6, dq_byte=B8, dq_ip=0x0000.
  - Popping 6 bytes yields that sequence with dq_ip 0..5.
- Segment wrap: flush cs=0xFFFF ip=0x0100 -> first req_addr=0x000F0.
- IP wrap: flush cs=0x1000 ip=0xFFFF -> req_addr 0x1FFFF then 0x10000; dq_ip 0xFFFF then 0x0000.
- Flush with 2 outstanding (latency 3), new ip=0x0028 -> both old responses dropped; first dq_byte=mem[0x28], dq_ip=0x0028.
- rsp_err on address 0x00004 -> bytes 0..3 delivered normally, then dq_fault=1 with dq_ip=0x0004; no req_valid until flush; flush clears faulted.
- Throttling: dq_ready toggling randomly for 500 cycles, and rst_n pulsed low mid-burst -> dq_count+outstanding<=6 always; after reset, outputs at reset values, restart at addr 0x00000.
